// File: rtl/fsk4_in_if.sv
// Byte-stream valid/ready bus feeding the 4-FSK modulator.
// The master drives bytes; the slave (modulator) returns in_ready.
interface fsk4_in_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fsk4_modulator.sv
// 4-FSK transmitter: bytes -> 2-bit symbols (MSB pair first) -> sync preamble + NCO I/Q samples.
// Optional PHASE_RESET_EN: restart the NCO at phase 0 on every symbol's first sample.
module fsk4_modulator #(
  parameter int unsigned SPS      = 99,
  parameter int unsigned SYNC_LEN = 10,
  parameter int unsigned AMP      = 100000,
  parameter int unsigned FS       = 90000000,
  parameter int unsigned FREQ0    = 1000000,
  parameter int unsigned FREQ1    = 2000000,
  parameter int unsigned FREQ2    = 3000000,
  parameter int unsigned FREQ3    = 4000000,
  parameter logic [1:0]  IDLE_SYM = 2'd0
) (
  input  logic               clk,
  input  logic               reset,
  fsk4_in_if.slave           in_if,
  output logic signed [17:0] dac_out_sin,
  output logic signed [17:0] dac_out_cos,
  output logic [1:0]         sym_out,
  output logic               sym_start,
  output logic               underflow,
  output logic               busy
);

  localparam int unsigned CNT_MAX = (SPS > SYNC_LEN) ? SPS : SYNC_LEN;
  localparam int          CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SPS_LAST  = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam real PI = 3.14159265358979323846;

  function automatic logic [31:0] pinc_of(input int unsigned f);
    logic [63:0] num;
    num = (64'(f) << 32) + 64'(FS / 2);
    return 32'(num / 64'(FS));
  endfunction

  function automatic logic signed [17:0] lut_val(input int k);
    real x;
    x = real'(AMP) * $sin(2.0 * PI * real'(k) / 1024.0);
    if (x >= 0.0) return 18'($rtoi(x + 0.5));
    else          return -18'($rtoi(-x + 0.5));
  endfunction

  localparam logic [31:0] PINC0 = pinc_of(FREQ0);
  localparam logic [31:0] PINC1 = pinc_of(FREQ1);
  localparam logic [31:0] PINC2 = pinc_of(FREQ2);
  localparam logic [31:0] PINC3 = pinc_of(FREQ3);

  // NOTE: the sine table is a constant ROM elaborated from the function above; it holds no state, so it takes no reset.
  logic signed [17:0] lut [1024];
  for (genvar k = 0; k < 1024; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SYM} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        phase_q, phase_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         shift_cnt_q, shift_cnt_d;
  logic signed [17:0] sin_q, sin_d, cos_q, cos_d;
  logic [1:0]         sym_q, sym_d;
  logic               start_q, start_d, uflow_q, uflow_d, busy_q, busy_d;

  logic        accept, drain;
  logic [1:0]  cur_sym;
  logic [31:0] phase_eff, pinc_cur;
  logic [9:0]  sin_idx, cos_idx;

  assign accept = in_if.in_valid && !hold_vld_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no inferred latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    sin_d       = '0;
    cos_d       = '0;
    sym_d       = sym_q;
    start_d     = 1'b0;
    uflow_d     = 1'b0;
    busy_d      = 1'b0;
    drain       = 1'b0;
    cur_sym     = sym_q;
    phase_eff   = phase_q;
    pinc_cur    = PINC0;
    sin_idx     = '0;
    cos_idx     = '0;

    case (state_q)
      S_IDLE: begin
        sym_d = 2'd0;
        if (accept) begin
          state_d = S_SYNC;
          cnt_d   = '0;
        end
      end
      S_SYNC: begin
        busy_d = 1'b1;
        sin_d  = 18'(AMP);
        sym_d  = 2'd0;
        if (cnt_q == SYNC_LAST) begin
          state_d = S_SYM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SYM: begin
        busy_d = 1'b1;
        // Symbol boundary: shift register first, then the hold byte, else idle substitution.
        if (cnt_q == '0) begin
          start_d = 1'b1;
          if (shift_cnt_q != 3'd0) begin
            cur_sym     = shift_q[7:6];
            shift_d     = {shift_q[5:0], 2'b00};
            shift_cnt_d = shift_cnt_q - 3'd1;
          end else if (hold_vld_q) begin
            cur_sym     = hold_q[7:6];
            shift_d     = {hold_q[5:0], 2'b00};
            shift_cnt_d = 3'd3;
            drain       = 1'b1;
          end else begin
            cur_sym = IDLE_SYM;
            uflow_d = 1'b1;
          end
`ifdef PHASE_RESET_EN
          phase_eff = '0;
`else
          phase_eff = phase_q;
`endif
        end
        case (cur_sym)
          2'd0:    pinc_cur = PINC0;
          2'd1:    pinc_cur = PINC1;
          2'd2:    pinc_cur = PINC2;
          default: pinc_cur = PINC3;
        endcase
        sym_d   = cur_sym;
        sin_idx = phase_eff[31:22];
        cos_idx = sin_idx + 10'd256;
        sin_d   = lut[sin_idx];
        cos_d   = lut[cos_idx];
        phase_d = phase_eff + pinc_cur;
        cnt_d   = (cnt_q == SPS_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (drain)  hold_vld_d = 1'b0;
    if (accept) begin
      hold_d     = in_if.in_data;
      hold_vld_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      shift_q     <= '0;
      shift_cnt_q <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      sym_q       <= '0;
      start_q     <= 1'b0;
      uflow_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      sym_q       <= sym_d;
      start_q     <= start_d;
      uflow_q     <= uflow_d;
      busy_q      <= busy_d;
    end
  end

  assign in_if.in_ready = !hold_vld_q;
  assign dac_out_sin    = sin_q;
  assign dac_out_cos    = cos_q;
  assign sym_out        = sym_q;
  assign sym_start      = start_q;
  assign underflow      = uflow_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fsk4_modulator.sv
// Scoreboard bench for fsk4_modulator: random byte streams, expected symbols queued at acceptance,
// a negedge monitor replays preamble/NCO behaviour from plain arithmetic and compares every sample.
module tb_fsk4_modulator;

  localparam int         SPS      = 99;
  localparam int         SYNC_LEN = 10;
  localparam int         AMP      = 100000;
  localparam logic [1:0] IDLE_SYM = 2'd0;
  localparam longint     TWO32    = 64'd4294967296;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] dac_out_sin, dac_out_cos;
  logic [1:0]         sym_out;
  logic               sym_start, underflow, busy;

  fsk4_in_if bus ();

  fsk4_modulator dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (bus),
    .dac_out_sin (dac_out_sin),
    .dac_out_cos (dac_out_cos),
    .sym_out     (sym_out),
    .sym_start   (sym_start),
    .underflow   (underflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Tone increments for 1/2/3/4 MHz at 90 MS/s.
  function automatic longint pinc_ref(input logic [1:0] s);
    case (s)
      2'd0:    return 47721859;
      2'd1:    return 95443718;
      2'd2:    return 143165577;
      default: return 190887435;
    endcase
  endfunction

  function automatic logic signed [17:0] ref_sine(input int idx);
    real x;
    x = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
    return 18'($rtoi($floor(x + 0.5)));
  endfunction

  // ---------------- monitor / reference model ----------------
  typedef enum {M_IDLE, M_ARM, M_PRE, M_SYM} mode_e;
  mode_e      m_mode  = M_IDLE;
  int         m_cnt   = 0;
  longint     m_phase = 0;
  logic [1:0] m_sym   = 2'd0;

  initial begin
    logic signed [17:0] es, ec;
    logic               e_start, e_uf, in_bound;
    int                 idx, s_abs, c_abs;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_phase = 0;
        m_sym   = 2'd0;
        exp_q.delete();
      end else begin
        case (m_mode)
          M_IDLE, M_ARM: begin
            check("idle_out", {dac_out_sin, dac_out_cos, sym_out, sym_start, underflow, busy}, 64'd0);
            if (m_mode == M_ARM) begin
              m_mode = M_PRE;
              m_cnt  = 0;
            end else if (bus.in_valid && bus.in_ready) begin
              m_mode = M_ARM;
            end
          end
          M_PRE: begin
            check("preamble", {dac_out_sin, dac_out_cos, sym_out, sym_start, underflow, busy},
                  {18'(AMP), 18'd0, 2'd0, 1'b0, 1'b0, 1'b1});
            m_cnt++;
            if (m_cnt == SYNC_LEN) begin
              m_mode = M_SYM;
              m_cnt  = 0;
            end
          end
          M_SYM: begin
            e_start = (m_cnt == 0);
            e_uf    = 1'b0;
            if (m_cnt == 0) begin
              if (exp_q.size() > 0) begin
                m_sym = exp_q.pop_front();
              end else begin
                m_sym = IDLE_SYM;
                e_uf  = 1'b1;
              end
`ifdef PHASE_RESET_EN
              m_phase = 0;
`endif
            end
            idx = int'(m_phase / 4194304);
            es  = ref_sine(idx);
            ec  = ref_sine((idx + 256) % 1024);
            check("sample", {dac_out_sin, dac_out_cos, sym_out, sym_start, underflow, busy},
                  {es, ec, m_sym, e_start, e_uf, 1'b1});
            s_abs    = (dac_out_sin < 0) ? -int'(dac_out_sin) : int'(dac_out_sin);
            c_abs    = (dac_out_cos < 0) ? -int'(dac_out_cos) : int'(dac_out_cos);
            in_bound = (s_abs <= AMP) && (c_abs <= AMP);
            check("amp_bound", 64'(in_bound), 64'd1);
            m_phase = (m_phase + pinc_ref(m_sym)) % TWO32;
            m_cnt   = (m_cnt + 1) % SPS;
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; leaves in_valid high so the next byte can follow back-to-back.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        for (int k = 3; k >= 0; k--) exp_q.push_back(b[2*k +: 2]);
      end
      @(posedge clk);
      #1;
    end
    check("byte_accepted", 64'(got), 64'd1);
    if (!got) bus.in_valid = 1'b0;
  endtask

  task automatic end_stream();
    bus.in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_async", {dac_out_sin, dac_out_cos, sym_out, sym_start, underflow, busy, bus.in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(3);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {dac_out_sin, dac_out_cos, sym_out, sym_start, underflow, busy, bus.in_ready}, 64'd1);
    reset = 1'b0;
    wait_cycles(5);

    // Single byte from idle, then run into idle-symbol substitution.
    send_byte(8'h1B);
    end_stream();
    wait_cycles(SYNC_LEN + 6 * SPS + 5);
    pulse_reset();

    // Two bytes back-to-back: second accepted while the first transmits.
    send_byte(8'hE4);
    send_byte(8'h55);
    end_stream();
    wait_cycles(SYNC_LEN + 9 * SPS + 20);
    pulse_reset();

    // Random streams, each cut short by a reset at a random point.
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = int'($urandom_range(1, 3));
      for (int j = 0; j < nb; j++) send_byte(8'($urandom));
      end_stream();
      wait_cycles(int'($urandom_range(40, 5 * SPS)));
      pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
